// File: rtl/onehot_debouncer.sv
// onehot_debouncer
//   Qualifies a single pressed key out of eight raw, asynchronous key lines and
//   presents it as a one-hot word to a downstream 8-to-3 encoder through a
//   valid/ready handshake. A key is accepted only after it has been seen alone
//   and unchanged for DEBOUNCE_CYCLES consecutive synchronized cycles; once
//   accepted, no further key is taken until every key has been released.
//
//   Optional feature (macro ONEHOT_DEBOUNCER_ERR_EN): adds an error output that
//   pulses for one cycle when a multi-key press appears while idle. Without the
//   macro the port and its logic are absent and multi-key presses are ignored.
//
// Ports
//   clk    in   1  clock, all state updates on the rising edge
//   rst_n  in   1  asynchronous active-low reset
//   keys   in   8  raw key lines, 1 = pressed
//   ready  in   1  downstream takes data when valid && ready at a rising edge
//   data   out  8  accepted one-hot key (8'h00 after reset)
//   valid  out  1  data holds an accepted key
//   error  out  1  multi-key press pulse (only with ONEHOT_DEBOUNCER_ERR_EN)
module onehot_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] keys,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid
`ifdef ONEHOT_DEBOUNCER_ERR_EN
  ,
  output logic       error
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Count value on which the candidate has been stable for DEBOUNCE_CYCLES edges.
  localparam logic [7:0] LAST_CNT = 8'(DEBOUNCE_CYCLES - 1);

  state_t     state;
  logic [7:0] sync_p0;
  logic [7:0] sync_p1;
  logic [7:0] ks;
  logic [7:0] cand;
  logic [7:0] cnt;

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
  endfunction

  function automatic logic is_multihot(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'h00;
  endfunction

  assign ks = sync_p1;

`ifdef ONEHOT_DEBOUNCER_ERR_EN
  // Previous synchronized value, so a multi-hot condition is flagged only on
  // its first appearance rather than every cycle it persists.
  logic [7:0] ks_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_prev <= 8'h00;
      error   <= 1'b0;
    end else begin
      ks_prev <= ks;
      error   <= (state == IDLE) && is_multihot(ks) && !is_multihot(ks_prev);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 8'h00;
      sync_p1 <= 8'h00;
      state   <= IDLE;
      cand    <= 8'h00;
      cnt     <= 8'h00;
      data    <= 8'h00;
      valid   <= 1'b0;
    end else begin
      // Stage p0 -> p1: two-flop synchronizer for the raw key lines
      sync_p0 <= keys;
      sync_p1 <= sync_p0;

      // FSM on the synchronized value ks
      case (state)
        IDLE: begin
          // Zero and multi-hot patterns are never taken as a candidate.
          if (is_onehot(ks)) begin
            cand  <= ks;
            cnt   <= 8'h00;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (ks != cand) begin
            cnt   <= 8'h00;
            state <= IDLE;
          end else if (cnt == LAST_CNT) begin
            data  <= cand;
            valid <= 1'b1;
            state <= HOLD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HOLD: begin
          // data is frozen here whatever keys does; only the handshake leaves.
          if (ready) begin
            valid <= 1'b0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (ks == 8'h00) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_debouncer.sv
module tb_onehot_debouncer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] keys, keys2;
  logic       ready, ready2;
  logic [7:0] data, data2;
  logic       valid, valid2;
`ifdef ONEHOT_DEBOUNCER_ERR_EN
  logic       error, error2;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  onehot_debouncer #(.DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .keys(keys), .ready(ready),
    .data(data), .valid(valid)
`ifdef ONEHOT_DEBOUNCER_ERR_EN
    , .error(error)
`endif
  );

  onehot_debouncer #(.DEBOUNCE_CYCLES(1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .keys(keys2), .ready(ready2),
    .data(data2), .valid(valid2)
`ifdef ONEHOT_DEBOUNCER_ERR_EN
    , .error(error2)
`endif
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; keys = 8'h00; keys2 = 8'h00; ready = 1'b0; ready2 = 1'b0;
    #12;
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", valid); end
    vectors++;
    if (data !== 8'h00) begin miscompares++; $display("FAIL reset_data got=%h exp=00", data); end
    vectors++;
    if (valid2 !== 1'b0 || data2 !== 8'h00) begin
      miscompares++; $display("FAIL reset_fast got=%b/%h exp=0/00", valid2, data2);
    end
`ifdef ONEHOT_DEBOUNCER_ERR_EN
    vectors++;
    if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error got=%b exp=0", error); end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(2);
  endtask

  // keys=04 at t0 held, ready=1: valid only at edge 19, gone at edge 20.
  task automatic test_latency;
    keys = 8'h04; ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      vectors++;
      if (valid !== (i == 19)) begin
        miscompares++; $display("FAIL latency_valid edge=%0d got=%b exp=%b", i, valid, (i == 19));
      end
      if (i == 19) begin
        vectors++;
        if (data !== 8'h04) begin miscompares++; $display("FAIL latency_data got=%h exp=04", data); end
      end
    end
    vectors++;
    if (data !== 8'h04) begin miscompares++; $display("FAIL latency_retain got=%h exp=04", data); end
    keys = 8'h00;
    step(4);
  endtask

  // Bounce: 10 cycles pressed, 3 released, then pressed for good.
  task automatic test_bounce;
    keys = 8'h10; ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      vectors++;
      if (valid !== 1'b0) begin miscompares++; $display("FAIL bounce_press cyc=%0d got=%b exp=0", i, valid); end
    end
    keys = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step(1);
      vectors++;
      if (valid !== 1'b0) begin miscompares++; $display("FAIL bounce_gap cyc=%0d got=%b exp=0", i, valid); end
    end
    keys = 8'h10;
    for (int i = 1; i <= 19; i++) begin
      step(1);
      vectors++;
      if (valid !== (i == 19)) begin
        miscompares++; $display("FAIL bounce_valid edge=%0d got=%b exp=%b", i, valid, (i == 19));
      end
    end
    vectors++;
    if (data !== 8'h10) begin miscompares++; $display("FAIL bounce_data got=%h exp=10", data); end
    ready = 1'b1; step(1); ready = 1'b0;
    keys = 8'h00; step(4);
  endtask

  // Back-pressure with key change, then no re-acceptance until full release.
  task automatic test_hold;
    keys = 8'h80; ready = 1'b0;
    step(19);
    vectors++;
    if (valid !== 1'b1 || data !== 8'h80) begin
      miscompares++; $display("FAIL hold_accept got=%b/%h exp=1/80", valid, data);
    end
    keys = 8'h01;
    for (int i = 0; i < 50; i++) begin
      step(1);
      vectors++;
      if (valid !== 1'b1 || data !== 8'h80) begin
        miscompares++; $display("FAIL hold_stall cyc=%0d got=%b/%h exp=1/80", i, valid, data);
      end
    end
    ready = 1'b1;
    step(1);
    vectors++;
    if (valid !== 1'b0 || data !== 8'h80) begin
      miscompares++; $display("FAIL hold_handshake got=%b/%h exp=0/80", valid, data);
    end
    for (int i = 0; i < 25; i++) begin
      step(1);
      vectors++;
      if (valid !== 1'b0) begin miscompares++; $display("FAIL hold_release cyc=%0d got=%b exp=0", i, valid); end
    end
    keys = 8'h00; ready = 1'b0;
    step(3);
    keys = 8'h01;
    step(18);
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("FAIL hold_repress_early got=%b exp=0", valid); end
    step(1);
    vectors++;
    if (valid !== 1'b1 || data !== 8'h01) begin
      miscompares++; $display("FAIL hold_repress got=%b/%h exp=1/01", valid, data);
    end
    ready = 1'b1; step(1); ready = 1'b0;
    keys = 8'h00; step(4);
  endtask

  // Multi-hot press while idle, and multi-hot arriving mid-debounce.
  task automatic test_multihot;
    keys = 8'h03; ready = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      vectors++;
      if (valid !== 1'b0) begin miscompares++; $display("FAIL multi_valid edge=%0d got=%b exp=0", i, valid); end
`ifdef ONEHOT_DEBOUNCER_ERR_EN
      vectors++;
      if (error !== (i == 3)) begin
        miscompares++; $display("FAIL multi_error edge=%0d got=%b exp=%b", i, error, (i == 3));
      end
`endif
    end
    keys = 8'h00; step(4);
    keys = 8'h04; step(6);
    keys = 8'h06;
    for (int i = 1; i <= 25; i++) begin
      step(1);
      vectors++;
      if (valid !== 1'b0) begin miscompares++; $display("FAIL abort_valid edge=%0d got=%b exp=0", i, valid); end
`ifdef ONEHOT_DEBOUNCER_ERR_EN
      vectors++;
      if (error !== 1'b0) begin miscompares++; $display("FAIL abort_error edge=%0d got=%b exp=0", i, error); end
`endif
    end
    keys = 8'h00; ready = 1'b0; step(4);
  endtask

  // Reset during HOLD discards the key; still-held key is re-qualified.
  task automatic test_reset_mid;
    keys = 8'h02; ready = 1'b0;
    step(19);
    vectors++;
    if (valid !== 1'b1 || data !== 8'h02) begin
      miscompares++; $display("FAIL rmid_accept got=%b/%h exp=1/02", valid, data);
    end
    rst_n = 1'b0;
    #2;
    vectors++;
    if (valid !== 1'b0 || data !== 8'h00) begin
      miscompares++; $display("FAIL rmid_async got=%b/%h exp=0/00", valid, data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      step(1);
      vectors++;
      if (valid !== (i == 19)) begin
        miscompares++; $display("FAIL rmid_valid edge=%0d got=%b exp=%b", i, valid, (i == 19));
      end
    end
    vectors++;
    if (data !== 8'h02) begin miscompares++; $display("FAIL rmid_data got=%h exp=02", data); end
    ready = 1'b1; step(1); ready = 1'b0;
    keys = 8'h00; step(4);
  endtask

  // DEBOUNCE_CYCLES=1: latency 4, then a random one-hot stream with random stalls.
  task automatic test_fast;
    logic [7:0] k;
    int         got;
    int         stall;
    keys2 = 8'h20; ready2 = 1'b0;
    step(3);
    vectors++;
    if (valid2 !== 1'b0) begin miscompares++; $display("FAIL fast_edge3 got=%b exp=0", valid2); end
    step(1);
    vectors++;
    if (valid2 !== 1'b1 || data2 !== 8'h20) begin
      miscompares++; $display("FAIL fast_edge4 got=%b/%h exp=1/20", valid2, data2);
    end
    ready2 = 1'b1; step(1); ready2 = 1'b0;
    keys2 = 8'h00; step(4);
    for (int n = 0; n < 12; n++) begin
      k = 8'h01 << $urandom_range(0, 7);
      keys2 = k;
      got = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
        step(1);
        if (valid2 === 1'b1) got = 1;
      end
      vectors++;
      if (got == 0) begin
        miscompares++; $display("FAIL fast_timeout iter=%0d got=valid0 exp=valid1", n);
      end
      vectors++;
      if (data2 !== k) begin miscompares++; $display("FAIL fast_data iter=%0d got=%h exp=%h", n, data2, k); end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        ready2 = 1'b0; step(1);
        vectors++;
        if (valid2 !== 1'b1 || data2 !== k) begin
          miscompares++; $display("FAIL fast_stall iter=%0d got=%b/%h exp=1/%h", n, valid2, data2, k);
        end
      end
      ready2 = 1'b1; step(1);
      vectors++;
      if (valid2 !== 1'b0) begin miscompares++; $display("FAIL fast_hs iter=%0d got=%b exp=0", n, valid2); end
      ready2 = 1'($urandom_range(0, 1));
      keys2 = 8'h00; step(4);
    end
    ready2 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_latency;
    test_bounce;
    test_hold;
    test_multihot;
    test_reset_mid;
    test_fast;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
